// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 mux arbiter with registered grant/sel and registered shared data output.
// Optional hold-timeout release is compiled in when ARB_HOLD_EN is defined.
module rr_mux_arbiter #(
    parameter int unsigned W           = 4,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    input  logic [W-1:0] D,
    output logic [3:0]   grant,
    output logic [1:0]   sel,
    output logic [W-1:0] Y,
    output logic         valid
);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    localparam logic [3:0] HoldMax = 4'(HOLD_CYCLES - 1);

    state_e       r_state, w_state_d;
    logic [3:0]   r_grant, w_grant_d;
    logic [1:0]   r_sel, w_sel_d;
    logic [1:0]   r_ptr, w_ptr_d;
    logic [3:0]   r_cnt, w_cnt_d;
    logic [W-1:0] r_y;
    logic         r_valid;

    logic [1:0]   w_pick_idle;
    logic [1:0]   w_pick_rel;
    logic         w_hold_expired;
    logic         w_release;
    logic [W-1:0] w_mux;

    // First set request bit at or after start, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [1:0] start, input logic [3:0] rq);
        logic [1:0] idx;
        rr_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (rq[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    assign w_pick_idle = rr_pick(r_ptr, req);
    assign w_pick_rel  = rr_pick(r_sel + 2'd1, req);

`ifdef ARB_HOLD_EN
    assign w_hold_expired = (r_cnt == HoldMax);
`else
    assign w_hold_expired = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_sel_d   = r_sel;
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_cnt;
        w_release = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|req) begin
                    w_state_d = StOwn;
                    w_sel_d   = w_pick_idle;
                    w_grant_d = onehot(w_pick_idle);
                    w_cnt_d   = 4'd0;
                end
            end
            StOwn: begin
                w_release = !req[r_sel] || w_hold_expired;
                if (w_release) begin
                    w_ptr_d = r_sel + 2'd1;
                    w_cnt_d = 4'd0;
                    if (|req) begin
                        // Owner's own bit is eligible, so a lone requester is regranted at once.
                        w_sel_d   = w_pick_rel;
                        w_grant_d = onehot(w_pick_rel);
                    end else begin
                        w_state_d = StIdle;
                        w_grant_d = 4'b0000;
                    end
                end else begin
`ifdef ARB_HOLD_EN
                    w_cnt_d = r_cnt + 4'd1;
`else
                    w_cnt_d = (r_cnt == HoldMax) ? r_cnt : r_cnt + 4'd1;
`endif
                end
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = 4'b0000;
            end
        endcase
    end

    always_comb begin
        w_mux = '0;
        unique case (r_sel)
            2'd0: w_mux = A;
            2'd1: w_mux = B;
            2'd2: w_mux = C;
            2'd3: w_mux = D;
            default: w_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= 4'd0;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_sel   <= w_sel_d;
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
            r_y     <= (|r_grant) ? w_mux : '0;
            r_valid <= |r_grant;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign Y     = r_y;
    assign valid = r_valid;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: W, 4, data width of each requester input and of Y.
REQ-002 Parameter: HOLD_CYCLES, 4, maximum consecutive cycles one requester keeps the grant (range 1..15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: req  input  4  request vector; bit i = requester i (0=A, 1=B, 2=C, 3=D).
REQ-006 Port: A, B, C, D  input  W each  requester data inputs.
REQ-007 Port: grant  output  4  registered one-hot grant; all-zero when no owner.
REQ-008 Port: sel  output  2  registered index of current owner; drives the shared 4:1 mux.
REQ-009 Port: Y  output  W  registered shared data output.
REQ-010 Port: valid  output  1  registered; high when Y carries owner data.

Function
REQ-011 FSM states: IDLE (no owner), OWN (one owner holds grant).
REQ-012 IDLE: req==0 -> stay IDLE; req!=0 -> next cycle OWN, grant/sel = first set req bit searching from ptr upward, wrapping 3->0.
REQ-013 ptr: 2-bit round-robin pointer = (index of last released owner + 1) mod 4.
REQ-014 OWN: hold counter increments each cycle; counter=0 on first granted cycle.
REQ-015 Release when req[sel]==0 or (ARB_HOLD_EN defined and counter==HOLD_CYCLES-1).
REQ-016 On release: ptr <= sel+1; if any req bit set (owner's own bit included), new grant chosen same cycle by REQ-012 search from new ptr, state stays OWN, counter <= 0; else state <= IDLE, grant <= 0.
REQ-017 Owner still requesting at hold expiry with no other requester is regranted (back-to-back, no idle cycle).
REQ-018 Grant latency: req asserted at edge N (IDLE) -> grant/sel valid after edge N+1.
REQ-019 Y/valid latency: one cycle after grant; Y <= data[sel] while grant!=0, else Y <= 0; valid <= (grant!=0).
REQ-020 Requests arriving mid-ownership never preempt; they wait for release.
REQ-021 grant is always one-hot or zero; sel holds last value while grant==0.
REQ-022 Counter width 4 bits; never wraps (saturates at HOLD_CYCLES-1 when ARB_HOLD_EN undefined).

Reset
REQ-023 rst_n low at a rising edge: state <= IDLE, grant <= 0, sel <= 0, ptr <= 0, counter <= 0, Y <= 0, valid <= 0.
REQ-024 Reset asserted during OWN aborts ownership immediately; no release-side ptr update.
REQ-025 First arbitration after reset searches from requester 0.

Configuration
REQ-026 Macro ARB_HOLD_EN defined: hold-timeout release of REQ-015 active; fair sharing of the mux.
REQ-027 ARB_HOLD_EN undefined: owner keeps grant until req[sel] drops; HOLD_CYCLES ignored; timeout logic absent.

Verification
REQ-028 A=0,B=4,C=A,D=7, reset then req=0001 -> grant=0001, sel=0 after 1 cycle; Y=0, valid=1 after 2 cycles.
REQ-029 req=1111 held, ARB_HOLD_EN defined, HOLD_CYCLES=4 -> grants 0001,0010,0100,1000,0001 each for exactly 4 cycles; Y sequence 0,4,A,7.
REQ-030 req=0100 held alone, ARB_HOLD_EN defined -> grant stays 0100 continuously across expiries, valid never drops.
REQ-031 Owner B (sel=1), req 0010->1001 -> next cycle grant=1000 (ptr=2 search skips C), Y=7 a cycle later.
REQ-032 rst_n low for 1 cycle while OWN with sel=3 -> grant=0, Y=0, valid=0 next cycle; req=1001 afterward -> grant=0001.
REQ-033 ARB_HOLD_EN undefined, req=1111 for 20 cycles -> grant stays 0001 all 20 cycles.
